minisys_wb_stage: RTL
=====================

# minisys_wb_stage

Parametrised write-back stage for the Minisys-1A pipeline. It registers the MEM/WB boundary and owns the architectural HI/LO pair, so HI/LO state lives in this stage rather than being passed through from EX. It selects the register-file write value from ALU result, sign/zero-extended load data, link address or HI/LO, and drives the register-file write port and forwarding taps. It adds stall/flush handling, sub-word load alignment and MTHI/MTLO over the previous pass-through write-back.

## Interface
Parameters:
- DATA_W, 32, datapath width; must be 32 for sub-word load modes.
- REG_AW, 5, register address width.
- LINK_REG, 31, destination forced for link instructions.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_w  in  1  hold WB register and suppress commit.
- flush_w  in  1  load a bubble instead of the MEM instruction.
- valid_m  in  1  MEM slot holds a real instruction.
- regwrite_m, mem2reg_m, link_m, mfhi_m, mflo_m, mthi_m, mtlo_m, mdcs_m  in  1 each  control bits from MEM.
- load_size_m  in  2  BYTE/HALF/WORD, from package.
- load_sign_m  in  1  1 means sign-extend.
- write_reg_m  in  REG_AW  destination register.
- alu_out_m, read_data_m, pcplus4_m  in  DATA_W  result sources; alu_out_m[1:0] is the load byte offset.
- md_hi_m, md_lo_m  in  DATA_W  multiply/divide results.
- result_w  out  DATA_W  register-file write data.
- write_reg_w  out  REG_AW  register-file write address.
- reg_we_w  out  1  register-file write enable.
- hi_q, lo_q  out  DATA_W  architectural HI/LO.
- fwd_valid_w  out  1  result_w/write_reg_w usable for bypass.

## Operation
- WB register captures all *_m fields on each rising edge when !stall_w. If flush_w is also high, valid is loaded as 0.
- stall_w has priority over flush_w: while stalled, everything is held and flush is ignored.
- commit = valid_q & !stall_w.
- Result mux priority: link → pcplus4; mfhi → hi_q; mflo → lo_q; mem2reg → aligned load; otherwise alu_out.
- write_reg_w = link_q ? LINK_REG : write_reg_q.
- reg_we_w = commit & (regwrite_q | link_q) & (write_reg_w != 0).
- Load alignment, offset = alu_out_q[1:0]:
  - BYTE selects byte[offset].
  - HALF selects halfword[offset[1]]; offset[0] is ignored.
  - WORD passes read_data unchanged.
  - Extension follows load_sign_q.
- HI/LO update on commit, evaluated in order:
  - mdcs writes both HI and LO from md_hi/md_lo.
  - Otherwise mthi writes HI from alu_out; mtlo writes LO from alu_out.
  - mthi and mtlo together write both.
- fwd_valid_w = valid_q & (regwrite_q | link_q) & (write_reg_w != 0). It is not gated by stall.

## Timing
- Reset (asynchronous): all WB register fields, valid_q, hi_q and lo_q go to 0. Outputs then read result_w=0, write_reg_w=0, reg_we_w=0, fwd_valid_w=0.
- Latency: an instruction presented on *_m at edge N appears on result_w and reg_we_w during cycle N→N+1. HI/LO change at edge N+1.
- MFHI directly behind MULT: MULT commits HI at edge N+1, and the MFHI in WB during N+1→N+2 reads the new hi_q. No internal bypass is required.
- Stall held for k cycles: exactly one commit, on the first unstalled cycle. No duplicate HI/LO write.
- A bubble (valid_q=0) never writes the register file or HI/LO, whatever its control bits are.
- Reset mid-stall discards the held instruction.

## Structure
- Package minisys_pkg:
  - load_size_t with encodings BYTE=2'b00, HALF=2'b01, WORD=2'b10; 2'b11 is treated as WORD.
  - LINK_REG default.
- Sub-module minisys_load_align, combinational: inputs read_data, offset, size, sign; output is the extended word.
- The HI/LO register pair stays in the top level.

## Test plan
- Reset: hold rst_n=0 with stimulus on all inputs → every output 0; release → hi_q=lo_q=0.
- LB sign: read_data=0x12F45678, offset=2, BYTE, sign=1, write_reg=8 → result_w=0xFFFFFFF4, write_reg_w=8, reg_we_w=1. LHU offset=2 → 0x000012F4.
- MULT then MFHI: mdcs with md_hi=0xDEAD0001, md_lo=0x5 → after commit hi_q=0xDEAD0001, lo_q=5. Next-cycle MFHI to r3 → result_w=0xDEAD0001.
- JAL: link=1, write_reg=0, pcplus4=0x00400008 → write_reg_w=31, result_w=0x00400008, reg_we_w=1.
- Stall plus flush: MTLO alu_out=0x77 held by stall_w for 3 cycles with flush_w high in cycle 2 → lo_q becomes 0x77 exactly once, after stall drops. The following flushed slot gives reg_we_w=0.
- Writes to r0 (regwrite=1, write_reg=0) → reg_we_w=0, fwd_valid_w=0.

Source files
------------

// File: rtl/minisys_pkg.sv
// Shared types and constants for the Minisys-1A write-back stage.
//   load_size_t      : sub-word load width (2'b11 behaves as WORD)
//   LINK_REG_DEFAULT : register written by link instructions (jal/jalr)
package minisys_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } load_size_t;

    localparam int LINK_REG_DEFAULT = 31;

endpackage

// File: rtl/minisys_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it to the datapath width.
// Ports:
//   read_data [DATA_W] : raw word from data memory
//   offset    [2]      : byte offset within the word
//   size      [2]      : BYTE / HALF / WORD (2'b11 treated as WORD)
//   sign      [1]      : 1 = sign-extend, 0 = zero-extend
//   extWord   [DATA_W] : aligned, extended load value
module minisys_load_align
    import minisys_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] read_data,
    input  logic [1:0]        offset,
    input  load_size_t        size,
    input  logic              sign,
    output logic [DATA_W-1:0] extWord
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = read_data[{offset, 3'b000} +: 8];
        // offset[0] is ignored for halfwords: misaligned halves read the
        // halfword that contains the addressed byte.
        halfSel = read_data[{offset[1], 4'b0000} +: 16];
        case (size)
            BYTE:    extWord = {{(DATA_W-8){sign & byteSel[7]}}, byteSel};
            HALF:    extWord = {{(DATA_W-16){sign & halfSel[15]}}, halfSel};
            default: extWord = read_data;
        endcase
    end

endmodule

// File: rtl/minisys_wb_stage.sv
// Minisys-1A write-back stage. Registers the MEM/WB boundary, owns the
// architectural HI/LO pair, selects the register-file write value and
// drives the register-file write port plus forwarding taps.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   stall_w, flush_w     : hold WB register / load a bubble (stall wins)
//   valid_m + *_m        : MEM-stage instruction fields
//   result_w, write_reg_w, reg_we_w : register-file write port
//   hi_q, lo_q           : architectural HI/LO
//   fwd_valid_w          : WB result usable for bypass (not stall-gated)
module minisys_wb_stage
    import minisys_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = LINK_REG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_w,
    input  logic              flush_w,
    input  logic              valid_m,
    input  logic              regwrite_m,
    input  logic              mem2reg_m,
    input  logic              link_m,
    input  logic              mfhi_m,
    input  logic              mflo_m,
    input  logic              mthi_m,
    input  logic              mtlo_m,
    input  logic              mdcs_m,
    input  load_size_t        load_size_m,
    input  logic              load_sign_m,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] read_data_m,
    input  logic [DATA_W-1:0] pcplus4_m,
    input  logic [DATA_W-1:0] md_hi_m,
    input  logic [DATA_W-1:0] md_lo_m,
    output logic [DATA_W-1:0] result_w,
    output logic [REG_AW-1:0] write_reg_w,
    output logic              reg_we_w,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic              fwd_valid_w
);

    logic              validQ, regwriteQ, mem2regQ, linkQ;
    logic              mfhiQ, mfloQ, mthiQ, mtloQ, mdcsQ;
    load_size_t        loadSizeQ;
    logic              loadSignQ;
    logic [REG_AW-1:0] writeRegQ;
    logic [DATA_W-1:0] aluOutQ, readDataQ, pcplus4Q, mdHiQ, mdLoQ;
    logic [DATA_W-1:0] hiReg, loReg;
    logic [DATA_W-1:0] loadWord;
    logic              commit;

    // Fields are captured even on flush; only valid is cleared, so a bubble
    // carries stale control bits that commit/valid gating must neutralise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ    <= 1'b0;
            regwriteQ <= 1'b0;
            mem2regQ  <= 1'b0;
            linkQ     <= 1'b0;
            mfhiQ     <= 1'b0;
            mfloQ     <= 1'b0;
            mthiQ     <= 1'b0;
            mtloQ     <= 1'b0;
            mdcsQ     <= 1'b0;
            loadSizeQ <= BYTE;
            loadSignQ <= 1'b0;
            writeRegQ <= '0;
            aluOutQ   <= '0;
            readDataQ <= '0;
            pcplus4Q  <= '0;
            mdHiQ     <= '0;
            mdLoQ     <= '0;
        end else if (!stall_w) begin
            validQ    <= valid_m & ~flush_w;
            regwriteQ <= regwrite_m;
            mem2regQ  <= mem2reg_m;
            linkQ     <= link_m;
            mfhiQ     <= mfhi_m;
            mfloQ     <= mflo_m;
            mthiQ     <= mthi_m;
            mtloQ     <= mtlo_m;
            mdcsQ     <= mdcs_m;
            loadSizeQ <= load_size_m;
            loadSignQ <= load_sign_m;
            writeRegQ <= write_reg_m;
            aluOutQ   <= alu_out_m;
            readDataQ <= read_data_m;
            pcplus4Q  <= pcplus4_m;
            mdHiQ     <= md_hi_m;
            mdLoQ     <= md_lo_m;
        end
    end

    // A stalled instruction stays in WB without committing, so it commits
    // exactly once: on the first cycle the stall is released.
    assign commit = validQ & ~stall_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (commit) begin
            if (mdcsQ) begin
                hiReg <= mdHiQ;
                loReg <= mdLoQ;
            end else begin
                if (mthiQ) hiReg <= aluOutQ;
                if (mtloQ) loReg <= aluOutQ;
            end
        end
    end

    minisys_load_align #(.DATA_W(DATA_W)) uLoadAlign (
        .read_data (readDataQ),
        .offset    (aluOutQ[1:0]),
        .size      (loadSizeQ),
        .sign      (loadSignQ),
        .extWord   (loadWord)
    );

    always_comb begin
        result_w = aluOutQ;
        if (linkQ)         result_w = pcplus4Q;
        else if (mfhiQ)    result_w = hiReg;
        else if (mfloQ)    result_w = loReg;
        else if (mem2regQ) result_w = loadWord;
    end

    assign write_reg_w = linkQ ? REG_AW'(LINK_REG) : writeRegQ;
    assign fwd_valid_w = validQ & (regwriteQ | linkQ) & (write_reg_w != '0);
    assign reg_we_w    = fwd_valid_w & commit;
    assign hi_q        = hiReg;
    assign lo_q        = loReg;

endmodule
